// File: rtl/jk_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// jk_cmd_sequencer
// Upstream driver for the jkff_1 JK flip-flop. Commands (hold/reset/set/toggle
// plus a repeat length) arrive over a valid/ready handshake and are buffered in
// a small FIFO. Each command drives registered J/K for cmd_len+1 cycles, and
// back-to-back commands follow each other with no idle bubble. A shadow model
// of the flop tracks the expected Q and raises a sticky mismatch flag whenever
// the returned Q disagrees with it once the shadow state is known.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (push when both high)
//   cmd_op [1:0]          {J,K}: 00 hold, 01 reset, 10 set, 11 toggle
//   cmd_len [LEN_W-1:0]   repeat count, command lasts cmd_len+1 cycles
//   J, K                  registered drive to the downstream flop
//   busy                  high while a command is being driven
//   q_in                  Q returned from the downstream flop
//   q_exp, q_known        shadow Q and its validity
//   clr_err               synchronous clear of the mismatch flag
//   mismatch              sticky divergence flag
// -----------------------------------------------------------------------------
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             J,
  output logic             K,
  output logic             busy,
  input  logic             q_in,
  output logic             q_exp,
  output logic             q_known,
  input  logic             clr_err,
  output logic             mismatch
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = LEN_W + 2;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  // FIFO storage and bookkeeping
  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             push_s, pop_s, empty_s;
  logic [EW-1:0]    head_s;

  // Sequencer state
  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             j_q, j_d, k_q, k_d;

  // Shadow model and checker
  logic             q_exp_q, q_exp_d;
  logic             q_known_q, q_known_d;
  logic             mismatch_q, mismatch_d;

  // Ready depends on occupancy only, so a pop never frees a slot in the same cycle.
  assign cmd_ready = (count_q != FULL_CNT);
  assign push_s    = cmd_valid && cmd_ready;
  assign empty_s   = (count_q == '0);
  assign head_s    = mem_q[rd_ptr_q];

  assign J        = j_q;
  assign K        = k_q;
  assign busy     = (state_q == ST_DRIVE);
  assign q_exp    = q_exp_q;
  assign q_known  = q_known_q;
  assign mismatch = mismatch_q;

  // Next-state logic for the IDLE/DRIVE sequencer, including the pop decision.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    j_d     = j_q;
    k_d     = k_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s          = 1'b1;
          {j_d, k_d}     = head_s[EW-1 -: 2];
          rem_d          = head_s[LEN_W-1:0];
          state_d        = ST_DRIVE;
        end else begin
          j_d = 1'b0;
          k_d = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (rem_q == '0) begin
          if (!empty_s) begin
            // Chain straight into the next command without an idle cycle.
            pop_s      = 1'b1;
            {j_d, k_d} = head_s[EW-1 -: 2];
            rem_d      = head_s[LEN_W-1:0];
          end else begin
            j_d     = 1'b0;
            k_d     = 1'b0;
            state_d = ST_IDLE;
          end
        end else begin
          rem_d = rem_q - {{(LEN_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        j_d     = 1'b0;
        k_d     = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO occupancy update; a simultaneous push and pop cancels out.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Shadow JK model driven from the J/K currently presented to the flop.
  always_comb begin
    case ({j_q, k_q})
      2'b00:   q_exp_d = q_exp_q;
      2'b01:   q_exp_d = 1'b0;
      2'b10:   q_exp_d = 1'b1;
      2'b11:   q_exp_d = ~q_exp_q;
      default: q_exp_d = q_exp_q;
    endcase
    // Only an explicit set or reset pins down the flop's otherwise unknown state.
    q_known_d = q_known_q | (j_q ^ k_q);
  end

  // Sticky mismatch; clear wins over a coincident new error.
  always_comb begin
    if (clr_err) begin
      mismatch_d = 1'b0;
    end else if (q_known_q && (q_in != q_exp_q)) begin
      mismatch_d = 1'b1;
    end else begin
      mismatch_d = mismatch_q;
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= {cmd_op, cmd_len};
        wr_ptr_q        <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end
      count_q <= count_d;
    end
  end

  // Sequencer, shadow model and checker registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      j_q        <= 1'b0;
      k_q        <= 1'b0;
      q_exp_q    <= 1'b0;
      q_known_q  <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      j_q        <= j_d;
      k_q        <= k_d;
      q_exp_q    <= q_exp_d;
      q_known_q  <= q_known_d;
      mismatch_q <= mismatch_d;
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
module tb_jk_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_len = 4'd0;
  logic       J, K, busy;
  logic       q_in;
  logic       q_exp, q_known;
  logic       clr_err = 1'b0;
  logic       mismatch;

  // Behavioural stand-in for the downstream jkff_1 (no reset), with override.
  logic flop_q = 1'b1;
  logic force_en = 1'b0;
  logic force_val = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    case ({J, K})
      2'b01:   flop_q <= 1'b0;
      2'b10:   flop_q <= 1'b1;
      2'b11:   flop_q <= ~flop_q;
      default: flop_q <= flop_q;
    endcase
  end

  assign q_in = force_en ? force_val : flop_q;

  jk_cmd_sequencer #(.DEPTH(4), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .J(J), .K(K), .busy(busy),
    .q_in(q_in), .q_exp(q_exp), .q_known(q_known), .clr_err(clr_err),
    .mismatch(mismatch)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    clr_err   = 1'b0;
    force_en  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs", {J, K, busy, q_exp, q_known, mismatch}, 6'b000000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_ready", cmd_ready, 1'b1);
  endtask

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [3:0] len;
    logic [6:0] exp; // {J,K,busy,q_exp,q_known,cmd_ready,mismatch}
  } vec_t;

  vec_t tbl [13];

  initial begin
    int bcnt;
    logic jk_bad;
    logic busy_seen;

    // Single set, then three chained commands; expectations are post-edge.
    tbl[0]  = '{1'b1, 2'b10, 4'd0, 7'b0000010};
    tbl[1]  = '{1'b0, 2'b00, 4'd0, 7'b1010010};
    tbl[2]  = '{1'b0, 2'b00, 4'd0, 7'b0001110};
    tbl[3]  = '{1'b0, 2'b00, 4'd0, 7'b0001110};
    tbl[4]  = '{1'b1, 2'b10, 4'd1, 7'b0001110};
    tbl[5]  = '{1'b1, 2'b11, 4'd2, 7'b1011110};
    tbl[6]  = '{1'b1, 2'b01, 4'd0, 7'b1011110};
    tbl[7]  = '{1'b0, 2'b00, 4'd0, 7'b1111110};
    tbl[8]  = '{1'b0, 2'b00, 4'd0, 7'b1110110};
    tbl[9]  = '{1'b0, 2'b00, 4'd0, 7'b1111110};
    tbl[10] = '{1'b0, 2'b00, 4'd0, 7'b0110110};
    tbl[11] = '{1'b0, 2'b00, 4'd0, 7'b0000110};
    tbl[12] = '{1'b0, 2'b00, 4'd0, 7'b0000110};

    // Table: single command then back-to-back commands
    do_reset();
    for (int i = 0; i < 13; i++) begin
      cmd_valid = tbl[i].v;
      cmd_op    = tbl[i].op;
      cmd_len   = tbl[i].len;
      step();
      chk($sformatf("vec[%0d]", i), {J, K, busy, q_exp, q_known, cmd_ready, mismatch}, tbl[i].exp);
    end
    cmd_valid = 1'b0;

    // Fill FIFO with long toggles; valid held through the first pop-while-full
    do_reset();
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_len   = 4'd15;
    bcnt = 0;
    jk_bad = 1'b0;
    for (int e = 1; e <= 18; e++) begin
      step();
      chk($sformatf("fill_ready[%0d]", e), cmd_ready, (e <= 4 || e == 18) ? 1'b1 : 1'b0);
      if (busy) begin
        bcnt++;
        if ({J, K} != 2'b11) jk_bad = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    for (int g = 0; g < 200 && busy; g++) begin
      step();
      if (busy) begin
        bcnt++;
        if ({J, K} != 2'b11) jk_bad = 1'b1;
      end
    end
    chk("fill_busy_cycles", bcnt, 80);
    chk("fill_jk_toggle", jk_bad, 1'b0);
    chk("fill_idle_end", {busy, J, K, cmd_ready}, 4'b0001);

    // Toggles before any set/reset never arm the checker
    do_reset();
    force_en  = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_len   = 4'd3;
    for (int e = 1; e <= 7; e++) begin
      force_val = e[0];
      step();
      cmd_valid = 1'b0;
      chk($sformatf("unknown[%0d]", e), {q_known, mismatch}, 2'b00);
    end
    force_en  = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_len   = 4'd0;
    step();
    cmd_valid = 1'b0;
    step();
    chk("reset_cmd_jk", {J, K}, 2'b01);
    step();
    chk("known_after_reset", {q_exp, q_known}, 2'b01);
    step();
    chk("known_no_mismatch", mismatch, 1'b0);

    // Error injection and clear priority
    do_reset();
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_len   = 4'd0;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("err_set_known", {q_exp, q_known, mismatch}, 3'b110);
    force_en  = 1'b1;
    force_val = 1'b0;
    step();
    chk("err_detect", mismatch, 1'b1);
    force_en = 1'b0;
    step();
    chk("err_sticky1", mismatch, 1'b1);
    step();
    chk("err_sticky2", mismatch, 1'b1);
    clr_err = 1'b1;
    step();
    chk("err_clear", mismatch, 1'b0);
    force_en = 1'b1;
    step();
    chk("err_clear_priority", mismatch, 1'b0);
    force_en = 1'b0;
    clr_err  = 1'b0;
    step();
    chk("err_stays_clear", mismatch, 1'b0);

    // Reset mid-DRIVE with three commands queued
    do_reset();
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_len   = 4'd15;
    repeat (4) step();
    cmd_valid = 1'b0;
    step();
    chk("pre_reset_drive", {J, K, busy, q_known, cmd_ready}, 5'b10111);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {J, K, busy, q_known}, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    busy_seen = 1'b0;
    for (int e = 0; e < 20; e++) begin
      step();
      if (busy || J || K || !cmd_ready) busy_seen = 1'b1;
    end
    chk("no_stale_cmds", busy_seen, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
